bus_mem_responder: RTL and testbench

- Shared-bus memory target: the responder side of the read_q/write_q request protocol issued by CPU-side initiators (start/fetch managers).
- Decodes addresses in a fixed window and services single reads and writes against an internal word RAM.
- Claims the bus with is_bus_busy for the duration of a transaction and completes it with read_dn/write_dn plus an echoed address, so the initiator can match completion to its request.

---
 rtl/bus_mem_responder.sv | 208 ++++++++++++++++++++
 tb/tb_bus_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: shared-bus memory target for the read_q/write_q protocol.
// Decodes a fixed word window starting at BASE, services one read or write at
// a time against an internal word RAM, claims the bus with is_bus_busy and
// completes with read_dn/write_dn plus an echoed address LATENCY cycles after
// the request was sampled.
// Optional build macro BUS_MEM_RESP_ERR_EN: out-of-window requests are claimed
// and completed with read_e/write_e instead of being ignored.
module bus_mem_responder #(
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 8,
  parameter int          LATENCY    = 2,
  localparam int         ADDR_SIZE  = 32,
  localparam int         DATA_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_q,
  input  logic                 write_q,
  inout  logic [ADDR_SIZE-1:0] addr,
  inout  logic [DATA_SIZE-1:0] data,
  inout  logic                 is_bus_busy,
  output logic                 read_dn,
  output logic                 write_dn,
  output logic                 read_e,
  output logic                 write_e
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                 state_reg;
  logic [3:0]             cnt_reg;
  logic                   op_write_reg;
  logic                   op_err_reg;
  logic [DEPTH_LOG2-1:0]  offset_reg;
  logic [ADDR_SIZE-1:0]   addr_reg;
  logic [DATA_SIZE-1:0]   wdata_reg;
  logic [DATA_SIZE-1:0]   rdata_reg;
  logic                   busy_oe_reg;
  logic                   echo_oe_reg;
  logic                   data_oe_reg;
  logic                   read_dn_reg;
  logic                   write_dn_reg;
`ifdef BUS_MEM_RESP_ERR_EN
  logic                   read_e_reg;
  logic                   write_e_reg;
`endif

  logic [DATA_SIZE-1:0]   mem [WORDS];

  // Request decode. Strobes and the shared busy line count only when exactly 1,
  // so floating (z) or unknown values are treated as inactive / not busy.
  logic [ADDR_SIZE-1:0]   rel_addr;
  logic                   in_window;
  logic                   window_ok;
  logic                   rd_strobe;
  logic                   wr_strobe;
  logic                   bus_free;
  logic                   accept;

  assign rel_addr  = addr - BASE;
  assign in_window = (addr >= BASE) && ((rel_addr >> DEPTH_LOG2) == '0);
  assign rd_strobe = (read_q === 1'b1);
  assign wr_strobe = (write_q === 1'b1);
  assign bus_free  = !(is_bus_busy === 1'b1);

`ifdef BUS_MEM_RESP_ERR_EN
  assign window_ok = 1'b1;
`else
  assign window_ok = in_window;
`endif

  assign accept = (state_reg == IDLE) && bus_free && (rd_strobe || wr_strobe) && window_ok;

  // Describe the transaction that enters DONE at this edge; with LATENCY==1 it
  // comes straight from the bus, otherwise from the captured request.
  logic                   enter_done;
  logic                   done_write;
  logic                   done_err;
  logic [DEPTH_LOG2-1:0]  ram_addr;
  logic [DATA_SIZE-1:0]   ram_wdata;
  logic                   ram_we;
  logic                   ram_re;

  // Select the RAM access and completion kind for a transaction reaching DONE
  always_comb begin
    enter_done = 1'b0;
    done_write = op_write_reg;
    done_err   = op_err_reg;
    ram_addr   = offset_reg;
    ram_wdata  = wdata_reg;
    if (state_reg == IDLE && accept && LATENCY == 1) begin
      enter_done = 1'b1;
      done_write = wr_strobe;
      done_err   = !in_window;
      ram_addr   = rel_addr[DEPTH_LOG2-1:0];
      ram_wdata  = data;
    end else if (state_reg == WAIT && cnt_reg == 4'd1) begin
      enter_done = 1'b1;
    end
  end

  // A reset on the same edge aborts the transaction, so it must not write.
  assign ram_we = enter_done && done_write && !done_err && !rst;
  assign ram_re = enter_done && !done_write && !done_err;

  // Word RAM: write on entry to DONE, registered read feeding the data bus
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_re) begin
      rdata_reg <= mem[ram_addr];
    end
  end

  // Capture the accepted request (no reset needed, qualified by the FSM)
  always_ff @(posedge clk) begin
    if (accept) begin
      offset_reg <= rel_addr[DEPTH_LOG2-1:0];
      addr_reg   <= addr;
      wdata_reg  <= data;
    end
  end

  // Transaction FSM with registered bus drive enables and done/error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_write_reg <= 1'b0;
      op_err_reg   <= 1'b0;
      busy_oe_reg  <= 1'b0;
      echo_oe_reg  <= 1'b0;
      data_oe_reg  <= 1'b0;
      read_dn_reg  <= 1'b0;
      write_dn_reg <= 1'b0;
`ifdef BUS_MEM_RESP_ERR_EN
      read_e_reg   <= 1'b0;
      write_e_reg  <= 1'b0;
`endif
    end else begin
      echo_oe_reg  <= 1'b0;
      data_oe_reg  <= 1'b0;
      read_dn_reg  <= 1'b0;
      write_dn_reg <= 1'b0;
`ifdef BUS_MEM_RESP_ERR_EN
      read_e_reg   <= 1'b0;
      write_e_reg  <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_write_reg <= wr_strobe;
            op_err_reg   <= !in_window;
            busy_oe_reg  <= 1'b1;
            if (LATENCY == 1) begin
              state_reg <= DONE;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd1) begin
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        DONE: begin
          state_reg   <= IDLE;
          busy_oe_reg <= 1'b0;
        end
        default: begin
          state_reg   <= IDLE;
          busy_oe_reg <= 1'b0;
        end
      endcase
      if (enter_done) begin
        echo_oe_reg  <= 1'b1;
        data_oe_reg  <= !done_write && !done_err;
        read_dn_reg  <= !done_write && !done_err;
        write_dn_reg <= done_write && !done_err;
`ifdef BUS_MEM_RESP_ERR_EN
        read_e_reg   <= !done_write && done_err;
        write_e_reg  <= done_write && done_err;
`endif
      end
    end
  end

  assign is_bus_busy = busy_oe_reg  ? 1'b1 : 1'bz;
  assign addr        = echo_oe_reg  ? addr_reg : 'z;
  assign data        = data_oe_reg  ? rdata_reg : 'z;
  assign read_dn     = read_dn_reg  ? 1'b1 : 1'bz;
  assign write_dn    = write_dn_reg ? 1'b1 : 1'bz;
`ifdef BUS_MEM_RESP_ERR_EN
  assign read_e      = read_e_reg   ? 1'b1 : 1'bz;
  assign write_e     = write_e_reg  ? 1'b1 : 1'bz;
`else
  assign read_e      = 1'bz;
  assign write_e     = 1'bz;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Testbench for bus_mem_responder. Instance A: BASE=0x100, 16 words,
// LATENCY=2 (table-driven vectors, reset abort). Instance B: BASE=0, 256
// words, LATENCY=1 (back-to-back sequence). Released bus lines are compared
// as 0 (z bits folded to 0).
`timescale 1ns/1ps
module tb_bus_mem_responder;

`ifdef BUS_MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // status = {is_bus_busy, read_dn, write_dn, read_e, write_e}
  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_BUSY = 5'b10000;
  localparam logic [4:0] S_RDN  = 5'b11000;
  localparam logic [4:0] S_WDN  = 5'b10100;
  localparam logic [4:0] S_RE   = 5'b10010;
  localparam logic [4:0] S_WE   = 5'b10001;
  localparam logic [4:0] OOW_RD = ERR_EN ? S_RE : S_IDLE;
  localparam logic [4:0] OOW_WR = ERR_EN ? S_WE : S_IDLE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A bus
  logic        a_rd = 1'b0, a_wr = 1'b0, a_addr_en = 1'b0, a_data_en = 1'b0, a_busy_en = 1'b0;
  logic [31:0] a_addr_drv = '0, a_data_drv = '0;
  wire  [31:0] a_addr, a_data;
  wire         a_busy, a_rdn, a_wdn, a_re, a_we;
  assign a_addr = a_addr_en ? a_addr_drv : 'z;
  assign a_data = a_data_en ? a_data_drv : 'z;
  assign a_busy = a_busy_en ? 1'b1 : 1'bz;
  wire  [4:0]  a_status = {a_busy, a_rdn, a_wdn, a_re, a_we};

  // Instance B bus
  logic        b_rd = 1'b0, b_wr = 1'b0, b_addr_en = 1'b0, b_data_en = 1'b0;
  logic [31:0] b_addr_drv = '0, b_data_drv = '0;
  wire  [31:0] b_addr, b_data;
  wire         b_busy, b_rdn, b_wdn, b_re, b_we;
  assign b_addr = b_addr_en ? b_addr_drv : 'z;
  assign b_data = b_data_en ? b_data_drv : 'z;
  wire  [4:0]  b_status = {b_busy, b_rdn, b_wdn, b_re, b_we};

  bus_mem_responder #(.BASE(32'h0000_0100), .DEPTH_LOG2(4), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst), .read_q(a_rd), .write_q(a_wr),
    .addr(a_addr), .data(a_data), .is_bus_busy(a_busy),
    .read_dn(a_rdn), .write_dn(a_wdn), .read_e(a_re), .write_e(a_we)
  );

  bus_mem_responder #(.BASE(32'h0000_0000), .DEPTH_LOG2(8), .LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst), .read_q(b_rd), .write_q(b_wr),
    .addr(b_addr), .data(b_data), .is_bus_busy(b_busy),
    .read_dn(b_rdn), .write_dn(b_wdn), .read_e(b_re), .write_e(b_we)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] zf(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (v[i] === 1'bz) ? 1'b0 : v[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (zf(act) !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, zf(act), exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ext_busy;
    logic [4:0]  exp_done;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ext_busy,
                              input logic [4:0] exp_done, input logic [31:0] exp_data);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.ext_busy = ext_busy; v.exp_done = exp_done; v.exp_data = exp_data;
    return v;
  endfunction

  // One LATENCY=2 transaction on instance A; called at negedge+1 of an idle cycle
  // and returns at negedge+1 of the first idle cycle after it.
  task automatic run_a(input vec_t v, input string tag);
    logic claimed;
    claimed = (v.exp_done != S_IDLE);
    a_rd = v.rd; a_wr = v.wr; a_addr_drv = v.addr; a_addr_en = 1'b1;
    a_data_drv = v.wdata; a_data_en = v.wr; a_busy_en = v.ext_busy;
    @(posedge clk);
    @(negedge clk);
    a_rd = 1'b0; a_wr = 1'b0; a_addr_en = 1'b0; a_data_en = 1'b0; a_busy_en = 1'b0;
    #1;
    chk({tag, " wait status"}, {27'b0, a_status}, {27'b0, claimed ? S_BUSY : S_IDLE});
    chk({tag, " wait addr"}, a_addr, 32'h0);
    @(negedge clk); #1;
    chk({tag, " done status"}, {27'b0, a_status}, {27'b0, v.exp_done});
    chk({tag, " done addr"}, a_addr, claimed ? v.addr : 32'h0);
    chk({tag, " done data"}, a_data, v.exp_data);
    $display("txn %s rd=%0b wr=%0b addr=%h status=%b data=%h", tag, v.rd, v.wr, v.addr, zf({27'b0, a_status}), zf(a_data));
    @(negedge clk); #1;
    chk({tag, " idle status"}, {27'b0, a_status}, {27'b0, S_IDLE});
    chk({tag, " idle addr"}, a_addr, 32'h0);
  endtask

  // One LATENCY=1 write on instance B
  task automatic write_b(input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    b_wr = 1'b1; b_addr_drv = addr; b_addr_en = 1'b1; b_data_drv = wdata; b_data_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_wr = 1'b0; b_addr_en = 1'b0; b_data_en = 1'b0;
    #1;
    chk({tag, " done status"}, {27'b0, b_status}, {27'b0, S_WDN});
    chk({tag, " done addr"}, b_addr, addr);
    chk({tag, " done data"}, b_data, 32'h0);
    $display("txn %s addr=%h status=%b", tag, addr, zf({27'b0, b_status}));
    @(negedge clk); #1;
    chk({tag, " idle status"}, {27'b0, b_status}, {27'b0, S_IDLE});
  endtask

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1'b0, 1'b1, 32'h105, 32'hDEADBEEF, 1'b0, S_WDN,  32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h105, 32'h0,        1'b0, S_RDN,  32'hDEADBEEF);
    vecs[2]  = mk(1'b0, 1'b1, 32'h10F, 32'h12345678, 1'b0, S_WDN,  32'h0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h10F, 32'h0,        1'b0, S_RDN,  32'h12345678);
    vecs[4]  = mk(1'b0, 1'b1, 32'h100, 32'h00000011, 1'b0, S_WDN,  32'h0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h110, 32'h0,        1'b0, OOW_RD, 32'h0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0FF, 32'h0,        1'b0, OOW_RD, 32'h0);
    vecs[7]  = mk(1'b0, 1'b1, 32'h110, 32'h0000AAAA, 1'b0, OOW_WR, 32'h0);
    vecs[8]  = mk(1'b1, 1'b0, 32'h100, 32'h0,        1'b0, S_RDN,  32'h00000011);
    vecs[9]  = mk(1'b1, 1'b1, 32'h102, 32'h00000005, 1'b0, S_WDN,  32'h0);
    vecs[10] = mk(1'b1, 1'b0, 32'h102, 32'h0,        1'b0, S_RDN,  32'h00000005);
    vecs[11] = mk(1'b1, 1'b0, 32'h105, 32'h0,        1'b1, S_IDLE, 32'h0);
    vecs[12] = mk(1'b1, 1'b0, 32'h105, 32'h0,        1'b0, S_RDN,  32'hDEADBEEF);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset a status", {27'b0, a_status}, {27'b0, S_IDLE});
    chk("reset a addr", a_addr, 32'h0);
    chk("reset b status", {27'b0, b_status}, {27'b0, S_IDLE});
    rst = 1'b0;

    // Table-driven vectors on instance A
    for (int i = 0; i < 13; i++) begin
      run_a(vecs[i], $sformatf("a_v%0d", i));
    end

    // Reset during WAIT aborts the read; stored data survives
    run_a(mk(1'b0, 1'b1, 32'h103, 32'h31415926, 1'b0, S_WDN, 32'h0), "a_rst_wr");
    a_rd = 1'b1; a_addr_drv = 32'h103; a_addr_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_rd = 1'b0; a_addr_en = 1'b0; rst = 1'b1;
    #1;
    chk("a_rst wait status", {27'b0, a_status}, {27'b0, S_BUSY});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("a_rst abort status", {27'b0, a_status}, {27'b0, S_IDLE});
    chk("a_rst abort addr", a_addr, 32'h0);
    chk("a_rst abort data", a_data, 32'h0);
    $display("txn a_rst read aborted status=%b", zf({27'b0, a_status}));
    run_a(mk(1'b1, 1'b0, 32'h103, 32'h0, 1'b0, S_RDN, 32'h31415926), "a_rst_rd");

    // Instance B, LATENCY=1: back-to-back reads, strobe during DONE ignored
    write_b(32'h10, 32'hCAFEF00D, "b_wr10");
    write_b(32'h11, 32'h0BADF00D, "b_wr11");
    b_rd = 1'b1; b_addr_drv = 32'h10; b_addr_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_addr_en = 1'b0;  // read_q stays high through the busy cycle
    #1;
    chk("b_rd10 done status", {27'b0, b_status}, {27'b0, S_RDN});
    chk("b_rd10 done addr", b_addr, 32'h10);
    chk("b_rd10 done data", b_data, 32'hCAFEF00D);
    $display("txn b_rd10 status=%b data=%h", zf({27'b0, b_status}), zf(b_data));
    @(posedge clk);
    @(negedge clk); #1;
    chk("b_busy_req ignored status", {27'b0, b_status}, {27'b0, S_IDLE});
    chk("b_busy_req ignored addr", b_addr, 32'h0);
    $display("txn b_busy_req status=%b", zf({27'b0, b_status}));
    b_addr_drv = 32'h11; b_addr_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_rd = 1'b0; b_addr_en = 1'b0;
    #1;
    chk("b_rd11 done status", {27'b0, b_status}, {27'b0, S_RDN});
    chk("b_rd11 done addr", b_addr, 32'h11);
    chk("b_rd11 done data", b_data, 32'h0BADF00D);
    $display("txn b_rd11 status=%b data=%h", zf({27'b0, b_status}), zf(b_data));
    @(negedge clk); #1;
    chk("b_rd11 idle status", {27'b0, b_status}, {27'b0, S_IDLE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
